// File: rtl/wbu_pipe_pkg.sv
// Shared encodings for the writeback stage: result sources, load sizes and FSM states.
package wbu_pipe_pkg;

    typedef enum logic [1:0] {
        ALU_RES = 2'd0,
        MEM_RES = 2'd1,
        PC4_RES = 2'd2,
        RSV_RES = 2'd3
    } res_src_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_WRITE    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wbu_load_ext.sv
// Combinational load extraction: shift raw read data by the byte offset, then
// sign- or zero-extend the selected byte/half/word/dword to XLEN.
module wbu_load_ext
    import wbu_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_data,
    input  logic [OFF_W-1:0] i_offset,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    output logic [XLEN-1:0]  o_data
);

    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_word;

    assign w_shifted = i_data >> {i_offset, 3'b000};

    // On a 32-bit datapath a dword request degenerates to a plain word.
    if (XLEN > 32) begin : g_wide
        assign w_word = (i_size == LD_D) ? w_shifted
                      : {{(XLEN-32){w_shifted[31] & ~i_unsigned}}, w_shifted[31:0]};
    end else begin : g_narrow
        assign w_word = w_shifted;
    end

    always_comb begin
        o_data = w_word;
        case (i_size)
            LD_B:    o_data = {{(XLEN-8){w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
            LD_H:    o_data = {{(XLEN-16){w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
            default: o_data = w_word;
        endcase
    end

endmodule

// File: rtl/wbu_pipe.sv
// Registered, handshaked writeback stage with multi-cycle load wait.
// Optional WBU_PERF_EN adds 64-bit retired-instruction and memory-stall counters.
module wbu_pipe
    import wbu_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [1:0]         in_result_src,
    input  logic               in_slt,
    input  logic               in_slt_src,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_reg_wr_en,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_unsigned,
    input  logic               mem_rsp_valid,
    input  logic [XLEN-1:0]    mem_rsp_data,
    output logic               rf_wr_en,
    output logic [RADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]    rf_wr_data,
    output logic               commit_valid,
    output logic [PC_W-1:0]    commit_pc,
    output logic               busy
`ifdef WBU_PERF_EN
    ,
    output logic [63:0]        perf_retired,
    output logic [63:0]        perf_mem_stall
`endif
);

    localparam int OFF_W = $clog2(XLEN / 8);

    wb_state_e          r_state;
    logic [PC_W-1:0]    r_pc;
    logic [RADDR_W-1:0] r_rd;
    logic               r_wr_en;
    logic [1:0]         r_ld_size;
    logic               r_ld_unsigned;
    logic [OFF_W-1:0]   r_offset;

    logic               r_rf_wr_en;
    logic [RADDR_W-1:0] r_rf_wr_addr;
    logic [XLEN-1:0]    r_rf_wr_data;
    logic               r_commit_valid;
    logic [PC_W-1:0]    r_commit_pc;

    logic               w_accept;
    logic               w_is_mem;
    logic [XLEN-1:0]    w_direct;
    logic [XLEN-1:0]    w_load;

    assign in_ready = (r_state != WB_WAIT_MEM);
    assign busy     = (r_state != WB_IDLE);
    assign w_accept = in_valid & in_ready;
    // An SLT result never needs memory data, even when tagged as a load.
    assign w_is_mem = (in_result_src == MEM_RES) & ~in_slt;

    always_comb begin
        w_direct = in_alu_result;
        if (in_slt)
            w_direct = {{(XLEN-1){1'b0}}, in_slt_src};
        else if (in_result_src == PC4_RES)
            w_direct = XLEN'(in_pc + PC_W'(4));
    end

    wbu_load_ext #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_ext (
        .i_data     (mem_rsp_data),
        .i_offset   (r_offset),
        .i_size     (r_ld_size),
        .i_unsigned (r_ld_unsigned),
        .o_data     (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= WB_IDLE;
            r_pc           <= '0;
            r_rd           <= '0;
            r_wr_en        <= 1'b0;
            r_ld_size      <= '0;
            r_ld_unsigned  <= 1'b0;
            r_offset       <= '0;
            r_rf_wr_en     <= 1'b0;
            r_rf_wr_addr   <= '0;
            r_rf_wr_data   <= '0;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
        end else begin
            r_rf_wr_en     <= 1'b0;
            r_commit_valid <= 1'b0;
            case (r_state)
                WB_WAIT_MEM: begin
                    if (mem_rsp_valid) begin
                        r_state        <= WB_WRITE;
                        r_commit_valid <= 1'b1;
                        r_commit_pc    <= r_pc;
                        if (r_wr_en && (r_rd != '0)) begin
                            r_rf_wr_en   <= 1'b1;
                            r_rf_wr_addr <= r_rd;
                            r_rf_wr_data <= w_load;
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_is_mem) begin
                            r_state       <= WB_WAIT_MEM;
                            r_pc          <= in_pc;
                            r_rd          <= in_rd;
                            r_wr_en       <= in_reg_wr_en;
                            r_ld_size     <= in_ld_size;
                            r_ld_unsigned <= in_ld_unsigned;
                            r_offset      <= in_alu_result[OFF_W-1:0];
                        end else begin
                            r_state        <= WB_WRITE;
                            r_commit_valid <= 1'b1;
                            r_commit_pc    <= in_pc;
                            if (in_reg_wr_en && (in_rd != '0)) begin
                                r_rf_wr_en   <= 1'b1;
                                r_rf_wr_addr <= in_rd;
                                r_rf_wr_data <= w_direct;
                            end
                        end
                    end else begin
                        r_state <= WB_IDLE;
                    end
                end
            endcase
        end
    end

    assign rf_wr_en     = r_rf_wr_en;
    assign rf_wr_addr   = r_rf_wr_addr;
    assign rf_wr_data   = r_rf_wr_data;
    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;

`ifdef WBU_PERF_EN
    logic [63:0] r_perf_retired;
    logic [63:0] r_perf_mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_retired   <= '0;
            r_perf_mem_stall <= '0;
        end else begin
            if (r_commit_valid)
                r_perf_retired <= r_perf_retired + 64'd1;
            if (r_state == WB_WAIT_MEM)
                r_perf_mem_stall <= r_perf_mem_stall + 64'd1;
        end
    end

    assign perf_retired   = r_perf_retired;
    assign perf_mem_stall = r_perf_mem_stall;
`endif

endmodule

// File: tb/tb_wbu_pipe.sv
// Self-checking bench for wbu_pipe: directed vector table, multi-cycle sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_wbu_pipe;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int PC_W    = 32;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [XLEN-1:0]    in_alu_result;
    logic [1:0]         in_result_src;
    logic               in_slt;
    logic               in_slt_src;
    logic [RADDR_W-1:0] in_rd;
    logic               in_reg_wr_en;
    logic [1:0]         in_ld_size;
    logic               in_ld_unsigned;
    logic               mem_rsp_valid;
    logic [XLEN-1:0]    mem_rsp_data;
    logic               rf_wr_en;
    logic [RADDR_W-1:0] rf_wr_addr;
    logic [XLEN-1:0]    rf_wr_data;
    logic               commit_valid;
    logic [PC_W-1:0]    commit_pc;
    logic               busy;
`ifdef WBU_PERF_EN
    logic [63:0]        perf_retired;
    logic [63:0]        perf_mem_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [RADDR_W-1:0] last_addr;
    logic [XLEN-1:0]    last_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wbu_pipe #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .PC_W    (PC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_alu_result  (in_alu_result),
        .in_result_src  (in_result_src),
        .in_slt         (in_slt),
        .in_slt_src     (in_slt_src),
        .in_rd          (in_rd),
        .in_reg_wr_en   (in_reg_wr_en),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .busy           (busy)
`ifdef WBU_PERF_EN
        ,
        .perf_retired   (perf_retired),
        .perf_mem_stall (perf_mem_stall)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [1:0]  src;
        logic        slt;
        logic        slt_src;
        logic [4:0]  rd;
        logic        wr_en;
        logic [1:0]  size;
        logic        uns;
        int          waitc;
        logic [31:0] mdata;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic [31:0] pc, logic [31:0] alu, logic [1:0] src,
                                logic slt, logic slt_src, logic [4:0] rd, logic wr_en,
                                logic [1:0] size, logic uns, int waitc, logic [31:0] mdata,
                                logic exp_en, logic [31:0] exp_data);
        vec_t v;
        v.pc = pc; v.alu = alu; v.src = src; v.slt = slt; v.slt_src = slt_src;
        v.rd = rd; v.wr_en = wr_en; v.size = size; v.uns = uns; v.waitc = waitc;
        v.mdata = mdata; v.exp_en = exp_en; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: load value from plain byte arithmetic.
    function automatic logic [31:0] ref_load(logic [31:0] d, logic [1:0] off,
                                             logic [1:0] size, logic uns);
        int nb;
        longint unsigned v;
        longint unsigned m;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        v  = {32'h0, d};
        v  = v >> (8 * int'(off));
        m  = (64'd1 << (8 * nb)) - 64'd1;
        v  = v & m;
        if (!uns && v[8*nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_result(logic [31:0] pc, logic [31:0] alu,
                                               logic [1:0] src, logic slt, logic slt_src);
        if (slt) return {31'h0, slt_src};
        if (src == 2'd2) return pc + 32'd4;
        return alu;
    endfunction

    task automatic drive_txn(input vec_t v);
        in_pc = v.pc; in_alu_result = v.alu; in_result_src = v.src;
        in_slt = v.slt; in_slt_src = v.slt_src; in_rd = v.rd; in_reg_wr_en = v.wr_en;
        in_ld_size = v.size; in_ld_unsigned = v.uns;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive_txn(v);
        in_valid = 1'b1;
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        if (v.src == 2'd1 && !v.slt) begin
            for (int w = 0; w < v.waitc; w++) begin
                chk({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
                chk({tag, "_stall_commit"}, 64'(commit_valid), 64'd0);
                tick();
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v.mdata;
            tick();
            mem_rsp_valid = 1'b0;
        end
        if (v.exp_en) begin
            last_addr = v.rd;
            last_data = v.exp_data;
        end
        chk({tag, "_wr_en"}, 64'(rf_wr_en), 64'(v.exp_en));
        chk({tag, "_addr"}, 64'(rf_wr_addr), 64'(last_addr));
        chk({tag, "_data"}, 64'(rf_wr_data), 64'(last_data));
        chk({tag, "_commit"}, 64'(commit_valid), 64'd1);
        chk({tag, "_pc"}, 64'(commit_pc), 64'(v.pc));
        tick();
        chk({tag, "_commit_drop"}, 64'(commit_valid), 64'd0);
        chk({tag, "_wr_drop"}, 64'(rf_wr_en), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_random(input int n);
        logic        pend;
        logic [31:0] p_pc;
        logic [4:0]  p_rd;
        logic        p_we;
        logic [1:0]  p_off;
        logic [1:0]  p_size;
        logic        p_uns;
        logic        exp_c;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
        logic        e_we;
        logic [31:0] e_data;
        logic        drain;
        longint      n_commit;
        longint      n_stall;
        pend = 1'b0; n_commit = 0; n_stall = 0;
        p_pc = '0; p_rd = '0; p_we = 1'b0; p_off = '0; p_size = '0; p_uns = 1'b0;
        e_pc = '0; e_rd = '0; e_we = 1'b0; e_data = '0;
        for (int i = 0; i < n; i++) begin
            drain = (i >= n - 10);
            in_pc          = $urandom & 32'hFFFF_FFFC;
            in_alu_result  = $urandom;
            in_result_src  = 2'($urandom_range(0, 3));
            in_slt         = ($urandom_range(0, 3) == 0);
            in_slt_src     = 1'($urandom_range(0, 1));
            in_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_reg_wr_en   = ($urandom_range(0, 4) != 0);
            in_ld_size     = 2'($urandom_range(0, 3));
            in_ld_unsigned = 1'($urandom_range(0, 1));
            mem_rsp_data   = $urandom;
            if (pend) begin
                in_valid      = drain ? 1'b0 : 1'($urandom_range(0, 1));
                mem_rsp_valid = drain ? 1'b1 : ($urandom_range(0, 2) == 0);
            end else begin
                in_valid      = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
                mem_rsp_valid = ($urandom_range(0, 3) == 0);
            end
            chk("rnd_ready", 64'(in_ready), 64'(!pend));
            exp_c = 1'b0;
            if (pend) begin
                n_stall++;
                if (mem_rsp_valid) begin
                    exp_c  = 1'b1;
                    e_pc   = p_pc; e_rd = p_rd; e_we = p_we;
                    e_data = ref_load(mem_rsp_data, p_off, p_size, p_uns);
                    pend   = 1'b0;
                end
            end else if (in_valid) begin
                if (in_result_src == 2'd1 && !in_slt) begin
                    pend  = 1'b1;
                    p_pc  = in_pc; p_rd = in_rd; p_we = in_reg_wr_en;
                    p_off = in_alu_result[1:0]; p_size = in_ld_size; p_uns = in_ld_unsigned;
                end else begin
                    exp_c  = 1'b1;
                    e_pc   = in_pc; e_rd = in_rd; e_we = in_reg_wr_en;
                    e_data = ref_result(in_pc, in_alu_result, in_result_src, in_slt, in_slt_src);
                end
            end
            tick();
            if (exp_c) n_commit++;
            if (exp_c && e_we && e_rd != 5'd0) begin
                last_addr = e_rd;
                last_data = e_data;
            end
            chk("rnd_commit", 64'(commit_valid), 64'(exp_c));
            chk("rnd_wr_en", 64'(rf_wr_en), 64'(exp_c && e_we && e_rd != 5'd0));
            chk("rnd_addr", 64'(rf_wr_addr), 64'(last_addr));
            chk("rnd_data", 64'(rf_wr_data), 64'(last_data));
            chk("rnd_busy", 64'(busy), 64'(pend || exp_c));
            if (exp_c) chk("rnd_pc", 64'(commit_pc), 64'(e_pc));
        end
        in_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        tick();
        tick();
`ifdef WBU_PERF_EN
        chk("perf_retired", perf_retired, 64'(n_commit));
        chk("perf_mem_stall", perf_mem_stall, 64'(n_stall));
`else
        chk("rnd_final_idle", 64'(busy), 64'(n_commit * 0 + n_stall * 0));
`endif
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_alu_result = '0; in_result_src = '0;
        in_slt = 1'b0; in_slt_src = 1'b0; in_rd = '0; in_reg_wr_en = 1'b0; in_ld_size = '0;
        in_ld_unsigned = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        last_addr = '0; last_data = '0;

        //       pc        alu           src   slt   ss    rd     we    sz    uns wait mdata          en    data
        vecs[0]  = mk(32'h100, 32'h1234,     2'd0, 1'b0, 1'b0, 5'd5,  1'b1, 2'd2, 1'b0, 0, 32'h0,         1'b1, 32'h0000_1234);
        vecs[1]  = mk(32'h104, 32'h5555,     2'd1, 1'b1, 1'b1, 5'd6,  1'b1, 2'd2, 1'b0, 0, 32'h0,         1'b1, 32'h1);
        vecs[2]  = mk(32'h108, 32'h5555,     2'd1, 1'b1, 1'b0, 5'd7,  1'b1, 2'd2, 1'b0, 0, 32'h0,         1'b1, 32'h0);
        vecs[3]  = mk(32'h10C, 32'h1002,     2'd1, 1'b0, 1'b0, 5'd8,  1'b1, 2'd0, 1'b0, 3, 32'h0080_0000, 1'b1, 32'hFFFF_FF80);
        vecs[4]  = mk(32'h110, 32'h1002,     2'd1, 1'b0, 1'b0, 5'd9,  1'b1, 2'd0, 1'b1, 3, 32'h0080_0000, 1'b1, 32'h0000_0080);
        vecs[5]  = mk(32'h200, 32'hABCD,     2'd2, 1'b0, 1'b0, 5'd1,  1'b1, 2'd2, 1'b0, 0, 32'h0,         1'b1, 32'h0000_0204);
        vecs[6]  = mk(32'h204, 32'h7777,     2'd0, 1'b0, 1'b0, 5'd0,  1'b1, 2'd2, 1'b0, 0, 32'h0,         1'b0, 32'h0);
        vecs[7]  = mk(32'h208, 32'h2002,     2'd1, 1'b0, 1'b0, 5'd10, 1'b1, 2'd1, 1'b0, 1, 32'h8001_0000, 1'b1, 32'hFFFF_8001);
        vecs[8]  = mk(32'h20C, 32'h3000,     2'd1, 1'b0, 1'b0, 5'd11, 1'b1, 2'd2, 1'b0, 2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        vecs[9]  = mk(32'h210, 32'h3004,     2'd1, 1'b0, 1'b0, 5'd12, 1'b1, 2'd3, 1'b0, 0, 32'h1234_5678, 1'b1, 32'h1234_5678);
        vecs[10] = mk(32'h214, 32'hCAFE,     2'd3, 1'b0, 1'b0, 5'd13, 1'b1, 2'd2, 1'b0, 0, 32'h0,         1'b1, 32'h0000_CAFE);
        vecs[11] = mk(32'h218, 32'h4000,     2'd1, 1'b0, 1'b0, 5'd14, 1'b1, 2'd1, 1'b1, 1, 32'h0000_F00F, 1'b1, 32'h0000_F00F);
        vecs[12] = mk(32'h21C, 32'h9999,     2'd0, 1'b0, 1'b0, 5'd9,  1'b0, 2'd2, 1'b0, 0, 32'h0,         1'b0, 32'h0);
        vecs[13] = mk(32'h220, 32'h5003,     2'd1, 1'b0, 1'b0, 5'd15, 1'b1, 2'd0, 1'b0, 2, 32'h7F00_0000, 1'b1, 32'h0000_007F);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rst_addr", 64'(rf_wr_addr), 64'd0);
        chk("rst_data", 64'(rf_wr_data), 64'd0);
        chk("rst_commit", 64'(commit_valid), 64'd0);
        chk("rst_pc", 64'(commit_pc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);

        // Back-to-back ALU ops with in_valid held high.
        for (int i = 0; i < 4; i++) begin
            drive_txn(mk(32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 2'd0, 1'b0, 1'b0,
                         5'(20 + i), 1'b1, 2'd2, 1'b0, 0, 32'h0, 1'b1, 32'h0));
            in_valid = 1'b1;
            chk("b2b_ready", 64'(in_ready), 64'd1);
            tick();
            chk("b2b_wr_en", 64'(rf_wr_en), 64'd1);
            chk("b2b_addr", 64'(rf_wr_addr), 64'(20 + i));
            chk("b2b_data", 64'(rf_wr_data), 64'(32'hA0 + 32'(i)));
            chk("b2b_pc", 64'(commit_pc), 64'(32'h300 + 32'(4 * i)));
            last_addr = 5'(20 + i);
            last_data = 32'hA0 + 32'(i);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_end_wr_en", 64'(rf_wr_en), 64'd0);
        chk("b2b_end_busy", 64'(busy), 64'd0);

        // Reset asserted while waiting on memory discards the load.
        drive_txn(mk(32'h400, 32'h1000, 2'd1, 1'b0, 1'b0, 5'd3, 1'b1, 2'd2, 1'b0,
                     0, 32'h0, 1'b1, 32'h0));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rstw_stall_ready", 64'(in_ready), 64'd0);
        chk("rstw_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rstw_addr", 64'(rf_wr_addr), 64'd0);
        chk("rstw_data", 64'(rf_wr_data), 64'd0);
        chk("rstw_ready", 64'(in_ready), 64'd1);
        chk("rstw_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_addr = '0;
        last_data = '0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rstw_post_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rstw_post_commit", 64'(commit_valid), 64'd0);
        chk("rstw_post_ready", 64'(in_ready), 64'd1);
        chk("rstw_post_data", 64'(rf_wr_data), 64'd0);
`ifdef WBU_PERF_EN
        chk("rstw_perf_stall", perf_mem_stall, 64'd0);
        chk("rstw_perf_retired", perf_retired, 64'd0);
`endif

        run_random(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/wbu_pipe.md
Name: wbu_pipe

Overview:
Registered, handshaked writeback stage that generalises the combinational result mux. It accepts one instruction per transfer from the memory stage, selects the final result (ALU, memory, SLT 0/1, PC+4), and aligns and sign-extends sub-word loads. It waits for a possibly multi-cycle memory response, then drives a single register-file write port and a commit strobe.

Parameters:
XLEN, 32, datapath and register width (32 or 64)
RADDR_W, 5, register address width
PC_W, 32, program counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction
in_pc  in  PC_W  instruction PC
in_alu_result  in  XLEN  ALU result or load address
in_result_src  in  2  0=ALU, 1=MEM, 2=PC+4, 3=reserved (treated as ALU)
in_slt  in  1  instruction is slt/sltu/slti/sltiu
in_slt_src  in  1  comparison outcome (1 = result one)
in_rd  in  RADDR_W  destination register
in_reg_wr_en  in  1  instruction writes rd
in_ld_size  in  2  0=byte, 1=half, 2=word, 3=dword (XLEN=64 only)
in_ld_unsigned  in  1  zero-extend load
mem_rsp_valid  in  1  memory read data valid (single-cycle pulse)
mem_rsp_data  in  XLEN  raw aligned-word read data
rf_wr_en  out  1  register-file write strobe
rf_wr_addr  out  RADDR_W  write address
rf_wr_data  out  XLEN  write data
commit_valid  out  1  instruction retired this cycle
commit_pc  out  PC_W  PC of retired instruction
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE. rf_wr_en, rf_wr_addr, rf_wr_data, commit_valid, commit_pc and busy are all 0. Reset asserted mid-WAIT_MEM discards the instruction; no write occurs.
- FSM states are IDLE, WAIT_MEM and WRITE. in_ready=1 in IDLE and WRITE, 0 in WAIT_MEM.
- Accept occurs when in_valid & in_ready. The stage captures pc, alu_result, src, slt, slt_src, rd, wr_en, ld_size, ld_unsigned and byte offset alu_result[log2(XLEN/8)-1:0].
- Result priority: slt overrides src, giving {0..,slt_src}. Otherwise ALU gives alu_result, PC+4 gives zero-extended pc+4, and MEM gives the extracted load.
- Non-MEM accepted in cycle N: state becomes WRITE, and rf_wr_* and commit_* assert in cycle N+1 for exactly one cycle.
- MEM accepted: state becomes WAIT_MEM. On the mem_rsp_valid cycle M, state becomes WRITE and the write and commit are visible in M+1.
- A mem_rsp_valid and an accept in the same cycle in WAIT_MEM cannot occur, because in_ready=0 there.
- WRITE with a new accept goes to WRITE or WAIT_MEM, giving back-to-back throughput of 1 instruction per cycle for non-MEM. WRITE with no accept returns to IDLE.
- mem_rsp_valid outside WAIT_MEM is ignored.
- Load extraction: shift mem_rsp_data right by offset*8, then take the low 8/16/32/64 bits and sign- or zero-extend to XLEN. Misaligned halfword/word is not supported; the offset is used as-is with upper bits truncated.
- rf_wr_en = captured wr_en & (rd != 0). A write to x0 never asserts rf_wr_en, but commit_valid still asserts. rf_wr_addr and rf_wr_data hold their last values when rf_wr_en=0.
- ld_size=3 with XLEN=32 is treated as a word access.

Optional Feature:
- Macro: WBU_PERF_EN.
- Defined: adds outputs perf_retired[63:0] (increments on commit_valid) and perf_mem_stall[63:0] (increments each WAIT_MEM cycle). Both reset to 0 and wrap modulo 2^64.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared macro file gains:
  - Result-source encodings: ALU_RES, MEM_RES, PC4_RES.
  - Load-size encodings: LD_B, LD_H, LD_W, LD_D.
  - State encodings: WB_IDLE, WB_WAIT_MEM, WB_WRITE.
- One sub-module, wbu_load_ext: a combinational shift/extend taking data, offset, size and unsigned, parametrised by XLEN.

Test Plan:
- ALU op: in_alu_result=0x1234, rd=5, src=0 → rf_wr_en=1, addr=5, data=0x00001234 one cycle after accept; commit_pc matches.
- SLT with slt_src=1, src=1 (MEM) → data=0x1 one cycle later, no wait for memory; with slt_src=0 → data=0x0.
- Load byte signed, offset=2, mem_rsp_data=0x00800000 after 3 wait cycles → in_ready=0 for those cycles, data=0xFFFFFF80; unsigned variant gives 0x00000080.
- Back-to-back: 4 ALU ops with in_valid held high → 4 consecutive rf_wr_en pulses, in_ready never drops.
- rd=0 with wr_en=1 → rf_wr_en=0, commit_valid=1.
- rst_n low during WAIT_MEM, then mem_rsp_valid pulse → no write, outputs 0, in_ready=1. With WBU_PERF_EN, perf_mem_stall=0 after reset.
